// File: rtl/bitcol_sched.sv
// Bit-column scheduler: turns per-group non-zero column masks into an MSB-first stream of
// shift offsets for the BCE, with one active group slot and a one-entry skid buffer.
module bitcol_sched (
   input  logic       clk,
   input  logic       rstn,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [6:0] in_index,
   input  logic       in_last,
   output logic       col_valid,
   input  logic       col_ready,
   output logic [2:0] col_offset,
   output logic       col_first,
   output logic       col_last,
   output logic [2:0] grp_ncols,
   output logic       grp_done,
   output logic       tile_done,
   output logic       busy
);

   logic       act_vld_q, act_vld_d;
   logic [6:0] act_mask_q, act_mask_d;
   logic       act_last_q, act_last_d;
   logic       act_first_q, act_first_d;
   logic [2:0] act_ncols_q, act_ncols_d;
   logic       nxt_vld_q, nxt_vld_d;
   logic [6:0] nxt_mask_q, nxt_mask_d;
   logic       nxt_last_q, nxt_last_d;

   logic [2:0] top_idx;
   logic [6:0] top_bit;
   logic       mask_nz;
   logic       mask_one;
   logic       issue;
   logic       retire;
   logic       act_free;
   logic       in_hs;

   function automatic logic [2:0] popcnt7(input logic [6:0] m);
      logic [2:0] c;
      c = '0;
      for (int i = 0; i < 7; i++) begin
         c = c + {2'b00, m[i]};
      end
      return c;
   endfunction

   // Ascending scan, so the highest set bit wins.
   always_comb begin
      top_idx = 3'd0;
      for (int i = 0; i < 7; i++) begin
         if (act_mask_q[i]) begin
            top_idx = 3'(i);
         end
      end
   end

   assign top_bit  = 7'd1 << top_idx;
   assign mask_nz  = (act_mask_q != 7'd0);
   assign mask_one = mask_nz && ((act_mask_q & (act_mask_q - 7'd1)) == 7'd0);

   assign col_valid  = act_vld_q && mask_nz;
   assign col_offset = top_idx;
   assign col_last   = col_valid && mask_one;
   assign col_first  = col_valid && act_first_q;

   assign issue    = col_valid && col_ready;
   // A zero-mask group retires after exactly one cycle in ACT.
   assign retire   = (issue && col_last) || (act_vld_q && !mask_nz);
   assign act_free = !act_vld_q || retire;

   assign in_ready = !nxt_vld_q;
   assign in_hs    = in_valid && in_ready;

   assign grp_done  = retire;
   assign tile_done = retire && act_last_q;
   assign grp_ncols = act_vld_q ? act_ncols_q : 3'd0;
   assign busy      = act_vld_q || nxt_vld_q;

   always_comb begin
      act_vld_d   = act_vld_q;
      act_mask_d  = act_mask_q;
      act_last_d  = act_last_q;
      act_first_d = act_first_q;
      act_ncols_d = act_ncols_q;
      nxt_vld_d   = nxt_vld_q;
      nxt_mask_d  = nxt_mask_q;
      nxt_last_d  = nxt_last_q;

      if (issue) begin
         act_mask_d  = act_mask_q & ~top_bit;
         act_first_d = 1'b0;
      end

      if (act_free) begin
         if (nxt_vld_q) begin
            act_vld_d   = 1'b1;
            act_mask_d  = nxt_mask_q;
            act_last_d  = nxt_last_q;
            act_first_d = 1'b1;
            act_ncols_d = popcnt7(nxt_mask_q);
            // in_ready is low while NXT is full, so no new descriptor can land here.
            nxt_vld_d   = in_hs;
         end else if (in_hs) begin
            act_vld_d   = 1'b1;
            act_mask_d  = in_index;
            act_last_d  = in_last;
            act_first_d = 1'b1;
            act_ncols_d = popcnt7(in_index);
         end else begin
            act_vld_d = 1'b0;
         end
      end else if (in_hs) begin
         nxt_vld_d  = 1'b1;
         nxt_mask_d = in_index;
         nxt_last_d = in_last;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         act_vld_q   <= 1'b0;
         act_mask_q  <= 7'd0;
         act_last_q  <= 1'b0;
         act_first_q <= 1'b0;
         act_ncols_q <= 3'd0;
         nxt_vld_q   <= 1'b0;
         nxt_mask_q  <= 7'd0;
         nxt_last_q  <= 1'b0;
      end else begin
         act_vld_q   <= act_vld_d;
         act_mask_q  <= act_mask_d;
         act_last_q  <= act_last_d;
         act_first_q <= act_first_d;
         act_ncols_q <= act_ncols_d;
         nxt_vld_q   <= nxt_vld_d;
         nxt_mask_q  <= nxt_mask_d;
         nxt_last_q  <= nxt_last_d;
      end
   end

endmodule

// File: tb/tb_bitcol_sched.sv
// Bench for bitcol_sched: a queue-of-groups model checked every cycle, plus directed scenarios
// with hand-computed literal expectations.
module tb_bitcol_sched;

   logic       clk;
   logic       rstn;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] in_index;
   logic       in_last;
   logic       col_valid;
   logic       col_ready;
   logic [2:0] col_offset;
   logic       col_first;
   logic       col_last;
   logic [2:0] grp_ncols;
   logic       grp_done;
   logic       tile_done;
   logic       busy;

   int n_pass  = 0;
   int n_total = 0;

   bitcol_sched dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_index   (in_index),
      .in_last    (in_last),
      .col_valid  (col_valid),
      .col_ready  (col_ready),
      .col_offset (col_offset),
      .col_first  (col_first),
      .col_last   (col_last),
      .grp_ncols  (grp_ncols),
      .grp_done   (grp_done),
      .tile_done  (tile_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
   endtask

   // Model: front of the queue is the group being issued, at most one more waits behind it.
   typedef struct {
      logic [6:0] mask;
      logic [6:0] rem;
      logic       last;
      int         issued;
   } grp_t;

   grp_t q[$];

   always @(negedge clk) begin : compare
      grp_t g;
      int   e_valid, e_off, e_first, e_last, e_ncols, e_done, e_tile;
      if (!rstn) q.delete();
      e_valid = 0; e_off = 0; e_first = 0; e_last = 0; e_ncols = 0; e_done = 0; e_tile = 0;
      if (q.size() > 0) begin
         g       = q[0];
         e_valid = (g.rem != 0) ? 1 : 0;
         e_off   = $clog2(int'(g.rem) + 1) - 1;
         e_first = (e_valid == 1 && g.issued == 0) ? 1 : 0;
         e_last  = (e_valid == 1 && $countones(g.rem) == 1) ? 1 : 0;
         e_ncols = $countones(g.mask);
         e_done  = (g.rem == 0 || (e_last == 1 && col_ready)) ? 1 : 0;
         e_tile  = (e_done == 1 && g.last) ? 1 : 0;
      end
      chk("col_valid", int'(col_valid), e_valid);
      if (e_valid == 1) chk("col_offset", int'(col_offset), e_off);
      chk("col_first", int'(col_first), e_first);
      chk("col_last", int'(col_last), e_last);
      chk("grp_ncols", int'(grp_ncols), e_ncols);
      chk("grp_done", int'(grp_done), e_done);
      chk("tile_done", int'(tile_done), e_tile);
      chk("busy", int'(busy), (q.size() > 0) ? 1 : 0);
      chk("in_ready", int'(in_ready), (q.size() < 2) ? 1 : 0);
      if (rstn) begin
         logic take;
         take = in_valid && (q.size() < 2);
         if (q.size() > 0) begin
            g = q[0];
            if (g.rem == 0) begin
               void'(q.pop_front());
            end else if (col_ready) begin
               g.rem    = g.rem - 7'(1 << e_off);
               g.issued = g.issued + 1;
               if (g.rem == 0) void'(q.pop_front());
               else q[0] = g;
            end
         end
         if (take) begin
            g.mask = in_index; g.rem = in_index; g.last = in_last; g.issued = 0;
            q.push_back(g);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0; in_valid = 1'b0; in_index = 7'd0; in_last = 1'b0; col_ready = 1'b1;
      tick; tick;
      #1;
      chk("rst in_ready", int'(in_ready), 1);
      chk("rst busy", int'(busy), 0);
      chk("rst col_valid", int'(col_valid), 0);
      rstn = 1'b1;
      tick;

      // Single group 1010010, last
      in_valid = 1'b1; in_index = 7'b1010010; in_last = 1'b1;
      tick;
      in_valid = 1'b0;
      #1;
      chk("s1 off6", int'(col_offset), 6);
      chk("s1 first", int'(col_first), 1);
      chk("s1 ncols", int'(grp_ncols), 3);
      tick; #1;
      chk("s1 off4", int'(col_offset), 4);
      tick; #1;
      chk("s1 off1", int'(col_offset), 1);
      chk("s1 last", int'(col_last), 1);
      chk("s1 tile_done", int'(tile_done), 1);
      tick; #1;
      chk("s1 idle", int'(busy), 0);

      // Back-to-back 0000011 then 1000000
      in_valid = 1'b1; in_index = 7'b0000011; in_last = 1'b0;
      tick;
      in_index = 7'b1000000; in_last = 1'b1;
      #1;
      chk("s2 off1", int'(col_offset), 1);
      chk("s2 ready", int'(in_ready), 1);
      tick;
      in_valid = 1'b0;
      #1;
      chk("s2 off0", int'(col_offset), 0);
      chk("s2 nxt full", int'(in_ready), 0);
      chk("s2 done0", int'(grp_done), 1);
      tick; #1;
      chk("s2 off6", int'(col_offset), 6);
      chk("s2 first6", int'(col_first), 1);
      chk("s2 ready back", int'(in_ready), 1);
      chk("s2 tile_done", int'(tile_done), 1);
      tick;

      // Zero-mask group
      in_valid = 1'b1; in_index = 7'd0; in_last = 1'b1;
      tick;
      in_valid = 1'b0;
      #1;
      chk("s3 col_valid", int'(col_valid), 0);
      chk("s3 grp_done", int'(grp_done), 1);
      chk("s3 tile_done", int'(tile_done), 1);
      chk("s3 busy", int'(busy), 1);
      tick; #1;
      chk("s3 idle", int'(busy), 0);

      // Backpressure on 0100100, second group buffered behind it
      col_ready = 1'b0;
      in_valid = 1'b1; in_index = 7'b0100100; in_last = 1'b0;
      tick;
      in_index = 7'b0000001; in_last = 1'b1;
      tick;
      in_valid = 1'b0;
      #1;
      chk("s4 hold off", int'(col_offset), 5);
      chk("s4 in_ready", int'(in_ready), 0);
      repeat (3) begin
         tick; #1;
         chk("s4 hold off", int'(col_offset), 5);
         chk("s4 hold first", int'(col_first), 1);
      end
      col_ready = 1'b1;
      tick; #1;
      chk("s4 off2", int'(col_offset), 2);
      chk("s4 done A", int'(grp_done), 1);
      chk("s4 tile A", int'(tile_done), 0);
      tick; #1;
      chk("s4 off0", int'(col_offset), 0);
      chk("s4 tile B", int'(tile_done), 1);
      tick;

      // Full mask
      in_valid = 1'b1; in_index = 7'b1111111; in_last = 1'b0;
      tick;
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         #1;
         chk("s6 off", int'(col_offset), 6 - i);
         chk("s6 ncols", int'(grp_ncols), 7);
         tick;
      end
      #1;
      chk("s6 idle", int'(busy), 0);

      // Reset in the middle of a group
      in_valid = 1'b1; in_index = 7'b1111111; in_last = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      rstn = 1'b0;
      #1;
      chk("s5 col_valid", int'(col_valid), 0);
      chk("s5 busy", int'(busy), 0);
      chk("s5 in_ready", int'(in_ready), 1);
      chk("s5 grp_done", int'(grp_done), 0);
      tick; tick;
      rstn = 1'b1;
      in_valid = 1'b1; in_index = 7'b0001000; in_last = 1'b1;
      tick;
      in_valid = 1'b0;
      #1;
      chk("s5 resume off", int'(col_offset), 3);
      chk("s5 resume tile", int'(tile_done), 1);
      tick; tick;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bitcol_sched.md
BITCOL_SCHED -- requirements
Module: bitcol_sched

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset:
- clk  in  1  rising-edge clock for all state
- rstn  in  1  asynchronous active-low reset
REQ-002 SHALL have the following group input port:
- in_valid  in  1  group descriptor offered
- in_ready  out  1  scheduler can accept a descriptor
- in_index  in  7  non-zero bit-column mask of the weight group; bit k means column k is non-zero
- in_last  in  1  descriptor is the last group of the tile
REQ-003 SHALL have the following column output port:
- col_valid  out  1  a shift offset is presented to the BCE
- col_ready  in  1  BCE consumes the presented offset
- col_offset  out  3  bit-column shift offset, 0..6
- col_first  out  1  presented column is the first of its group
- col_last  out  1  presented column is the last of its group
REQ-004 SHALL have the following status outputs:
- grp_ncols  out  3  popcount of the active group mask, held for the whole active group
- grp_done  out  1  single-cycle pulse when the active group retires
- tile_done  out  1  single-cycle pulse when a group with in_last retires
- busy  out  1  active or buffered group present

Function
REQ-005 SHALL hold two group slots:
- ACT: act_vld, act_mask[6:0], act_last, act_first, act_ncols
- NXT: nxt_vld, nxt_mask, nxt_last (one-entry skid buffer)
REQ-006 SHALL drive in_ready = !nxt_vld (registered flag; no combinational path from col_ready).
REQ-007 SHALL drive col_valid = act_vld && (act_mask != 0).
REQ-008 SHALL drive col_offset as the index of the highest set bit of act_mask, i.e. MSB-first issue order 6 down to 0.
REQ-009 SHALL drive col_last = col_valid && (exactly one bit of act_mask set).
REQ-010 SHALL drive col_first = col_valid && act_first.
REQ-011 SHALL, on col_valid && col_ready, clear the issued bit in act_mask and clear act_first.
REQ-012 SHALL define retire = (col_valid && col_ready && col_last) || (act_vld && act_mask == 0).
REQ-013 SHALL drive grp_done = retire and tile_done = retire && act_last, both combinational from registered state.
REQ-014 SHALL treat the ACT slot as free when !act_vld || retire.
REQ-015 SHALL, when ACT is free and nxt_vld, move NXT to ACT (act_first=1, act_ncols=popcount) and clear nxt_vld, or set nxt_vld if a new handshake targets NXT in the same cycle.
REQ-016 SHALL, on an input handshake (in_valid && in_ready), load ACT directly when ACT is free and nxt_vld=0, otherwise load NXT.
REQ-017 SHALL clear act_vld when ACT is free and nothing is loaded into it.
REQ-018 SHALL give latency: a descriptor accepted at edge T into a free ACT presents its first column in cycle T+1.
REQ-019 SHALL sustain throughput of one column per cycle across group boundaries with no bubble when NXT is full and col_ready=1.
REQ-020 SHALL treat a zero-mask group as follows:
- it occupies ACT for exactly one cycle with col_valid=0
- it pulses grp_done, plus tile_done if last
- grp_ncols=0
REQ-021 SHALL hold col_offset, col_first and col_last stable while col_valid && !col_ready.
REQ-022 SHALL drive grp_ncols = act_ncols when act_vld, else 0.
REQ-023 SHALL drive busy = act_vld || nxt_vld.

Reset
REQ-024 SHALL clear act_vld, nxt_vld, masks, act_first, act_last and act_ncols asynchronously on rstn low; all outputs are then 0 except in_ready=1.
REQ-025 SHALL discard in-flight groups on reset mid-operation, with no grp_done or tile_done for them; operation resumes on the first edge after rstn deasserts.

Verification
REQ-026 Scenario, single group:
- stimulus: in_index=7'b1010010, in_last=1, col_ready=1
- response: col_offset 6,4,1 on consecutive cycles starting T+1; col_first on 6, col_last on 1; grp_ncols=3; grp_done and tile_done on the offset-1 cycle
REQ-027 Scenario, back-to-back groups:
- stimulus: groups 7'b0000011 then 7'b1000000 offered back-to-back
- response: offsets 1,0,6 with no gap; grp_done pulses twice; in_ready drops for one cycle while NXT is full
REQ-028 Scenario, zero-mask group:
- stimulus: in_index=0, in_last=1
- response: one cycle with col_valid=0, grp_done=1, tile_done=1, grp_ncols=0
REQ-029 Scenario, backpressure:
- stimulus: col_ready=0 for 5 cycles on mask 7'b0100100
- response: col_offset=5 held stable; in_ready=0 after a second group is accepted; no descriptor lost
REQ-030 Scenario, reset mid-group:
- stimulus: rstn low after the first column of mask 7'b1111111
- response: col_valid=0, busy=0, in_ready=1 immediately; no grp_done
REQ-031 Scenario, full mask:
- stimulus: in_index=7'b1111111
- response: offsets 6..0 over seven handshakes; grp_ncols=7 throughout
